// File: rtl/ltc2320_decimator.sv
// Block averager for the LTC2320 8-channel frame stream: sums 2**LOG2_N frames per channel
// through one shared adder (one channel per cycle) and emits rounded averages with a strobe.
module ltc2320_decimator #(
  parameter int LOG2_N = 4
) (
  input  logic        clk_sys,
  input  logic        reset_sys,
  input  logic        ain_valid,
  input  logic [12:0] ain1_data,
  input  logic [12:0] ain2_data,
  input  logic [12:0] ain3_data,
  input  logic [12:0] ain4_data,
  input  logic [12:0] ain5_data,
  input  logic [12:0] ain6_data,
  input  logic [12:0] ain7_data,
  input  logic [12:0] ain8_data,
  input  logic        clear_overrun,
  output logic        avg_valid,
  output logic [12:0] avg1_data,
  output logic [12:0] avg2_data,
  output logic [12:0] avg3_data,
  output logic [12:0] avg4_data,
  output logic [12:0] avg5_data,
  output logic [12:0] avg6_data,
  output logic [12:0] avg7_data,
  output logic [12:0] avg8_data,
  output logic        busy,
  output logic        overrun
);

  localparam int AW = 13 + LOG2_N;
  localparam int RW = AW + 1;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CW-1:0]        LAST_FRAME = CW'((2 ** LOG2_N) - 1);
  localparam logic signed [RW-1:0] RND        = RW'((2 ** LOG2_N) / 2);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ch_q, ch_d;
  logic [CW-1:0]          fcnt_q, fcnt_d;
  logic [12:0]            cap_q   [8];
  logic [12:0]            cap_d   [8];
  logic signed [AW-1:0]   acc_q   [8];
  logic signed [AW-1:0]   acc_d   [8];
  logic [12:0]            stage_q [8];
  logic [12:0]            stage_d [8];
  logic [12:0]            avg_q   [8];
  logic [12:0]            avg_d   [8];
  logic                   avg_valid_q, avg_valid_d;
  logic                   overrun_q, overrun_d;

  logic [12:0]            ain [8];
  logic signed [12:0]     cap_cur;
  logic signed [AW-1:0]   cap_ext;
  logic signed [AW-1:0]   sum;
  logic signed [RW-1:0]   rounded;
  logic signed [12:0]     avg_rnd;

  always_comb begin
    ain[0] = ain1_data;
    ain[1] = ain2_data;
    ain[2] = ain3_data;
    ain[3] = ain4_data;
    ain[4] = ain5_data;
    ain[5] = ain6_data;
    ain[6] = ain7_data;
    ain[7] = ain8_data;
  end

  // Shared adder: the one channel selected by ch_q, plus round-half-up scaling.
  always_comb begin
    cap_cur = cap_q[ch_q];
    cap_ext = cap_cur;
    sum     = acc_q[ch_q] + cap_ext;
    rounded = RW'(sum) + RND;
    avg_rnd = 13'(rounded >>> LOG2_N);
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    fcnt_d      = fcnt_q;
    cap_d       = cap_q;
    acc_d       = acc_q;
    stage_d     = stage_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (ain_valid) begin
          cap_d   = ain;
          ch_d    = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (fcnt_q != LAST_FRAME) begin
          acc_d[ch_q] = sum;
        end else begin
          stage_d[ch_q] = avg_rnd;
          acc_d[ch_q]   = '0;
        end
        ch_d = ch_q + 3'd1;
        if (ch_q == 3'd7) begin
          if (fcnt_q == LAST_FRAME) begin
            fcnt_d  = '0;
            state_d = DONE;
          end else begin
            fcnt_d  = fcnt_q + 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        avg_d       = stage_q;
        avg_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A dropped frame in the same cycle as a clear must leave the flag set.
    if (clear_overrun) overrun_d = 1'b0;
    if (ain_valid && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      fcnt_q      <= '0;
      cap_q       <= '{default: '0};
      acc_q       <= '{default: '0};
      stage_q     <= '{default: '0};
      avg_q       <= '{default: '0};
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      fcnt_q      <= fcnt_d;
      cap_q       <= cap_d;
      acc_q       <= acc_d;
      stage_q     <= stage_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avg_valid = avg_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign avg1_data = avg_q[0];
  assign avg2_data = avg_q[1];
  assign avg3_data = avg_q[2];
  assign avg4_data = avg_q[3];
  assign avg5_data = avg_q[4];
  assign avg6_data = avg_q[5];
  assign avg7_data = avg_q[6];
  assign avg8_data = avg_q[7];

endmodule

// File: tb/tb_ltc2320_decimator.sv
// Directed bench for ltc2320_decimator: three instances (LOG2_N = 2, 0, 4) share one
// stimulus stream; each test checks only the instance it targets.
module tb_ltc2320_decimator;

  typedef int frame_t [8];
  typedef struct {
    string name;
    int    f [4][8];
    int    e [8];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ain_valid = 1'b0;
  logic        clr = 1'b0;
  logic [12:0] ain [8];

  logic        av2, busy2, ovr2;
  logic        av0, busy0, ovr0;
  logic        av4, busy4, ovr4;
  logic [12:0] avg2 [8];
  logic [12:0] avg0 [8];
  logic [12:0] avg4 [8];

  int checks = 0;
  int errors = 0;
  int n2 = 0;
  int n4 = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (av2) n2 <= n2 + 1;
    if (av4) n4 <= n4 + 1;
  end

  ltc2320_decimator #(.LOG2_N(2)) dut2 (
    .clk_sys(clk), .reset_sys(rst), .ain_valid(ain_valid),
    .ain1_data(ain[0]), .ain2_data(ain[1]), .ain3_data(ain[2]), .ain4_data(ain[3]),
    .ain5_data(ain[4]), .ain6_data(ain[5]), .ain7_data(ain[6]), .ain8_data(ain[7]),
    .clear_overrun(clr), .avg_valid(av2),
    .avg1_data(avg2[0]), .avg2_data(avg2[1]), .avg3_data(avg2[2]), .avg4_data(avg2[3]),
    .avg5_data(avg2[4]), .avg6_data(avg2[5]), .avg7_data(avg2[6]), .avg8_data(avg2[7]),
    .busy(busy2), .overrun(ovr2));

  ltc2320_decimator #(.LOG2_N(0)) dut0 (
    .clk_sys(clk), .reset_sys(rst), .ain_valid(ain_valid),
    .ain1_data(ain[0]), .ain2_data(ain[1]), .ain3_data(ain[2]), .ain4_data(ain[3]),
    .ain5_data(ain[4]), .ain6_data(ain[5]), .ain7_data(ain[6]), .ain8_data(ain[7]),
    .clear_overrun(clr), .avg_valid(av0),
    .avg1_data(avg0[0]), .avg2_data(avg0[1]), .avg3_data(avg0[2]), .avg4_data(avg0[3]),
    .avg5_data(avg0[4]), .avg6_data(avg0[5]), .avg7_data(avg0[6]), .avg8_data(avg0[7]),
    .busy(busy0), .overrun(ovr0));

  ltc2320_decimator #(.LOG2_N(4)) dut4 (
    .clk_sys(clk), .reset_sys(rst), .ain_valid(ain_valid),
    .ain1_data(ain[0]), .ain2_data(ain[1]), .ain3_data(ain[2]), .ain4_data(ain[3]),
    .ain5_data(ain[4]), .ain6_data(ain[5]), .ain7_data(ain[6]), .ain8_data(ain[7]),
    .clear_overrun(clr), .avg_valid(av4),
    .avg1_data(avg4[0]), .avg2_data(avg4[1]), .avg3_data(avg4[2]), .avg4_data(avg4[3]),
    .avg5_data(avg4[4]), .avg6_data(avg4[5]), .avg7_data(avg4[6]), .avg8_data(avg4[7]),
    .busy(busy4), .overrun(ovr4));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic frame_t fill(input int x);
    frame_t v;
    for (int k = 0; k < 8; k++) v[k] = x;
    return v;
  endfunction

  task automatic send_frame(input frame_t v);
    for (int k = 0; k < 8; k++) ain[k] = 13'(v[k]);
    ain_valid = 1'b1;
    tick();
    ain_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the LOG2_N=2 strobe; lat is the edge count, -1 on timeout.
  task automatic wait_strobe2(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (av2) begin
        lat = i;
        break;
      end
    end
  endtask

  // Full LOG2_N=2 block of four frames, 12 cycles apart.
  task automatic block2(input frame_t fr [4], input string name, output int lat);
    int base;
    base = n2;
    for (int f = 0; f < 3; f++) begin
      send_frame(fr[f]);
      idle(11);
    end
    chk({name, "_no_early_strobe"}, n2 - base, 0);
    send_frame(fr[3]);
    wait_strobe2(lat);
    chk({name, "_latency"}, lat, 9);
  endtask

  vec_t   vecs [3];
  frame_t blk  [4];
  frame_t fa, fb, v;
  int     lat, base, s [8];
  logic [12:0] r;

  initial begin
    for (int k = 0; k < 8; k++) ain[k] = '0;

    // ---------- vector table (LOG2_N = 2) ----------
    vecs[0].name = "const100";
    for (int f = 0; f < 4; f++) vecs[0].f[f] = '{100, 100, 100, 100, 100, 100, 100, 100};
    vecs[0].e = '{100, 100, 100, 100, 100, 100, 100, 100};

    vecs[1].name = "round_ext";
    vecs[1].f[0] = '{1, -6, -4096, 4095, 0, 0, -1, -1};
    vecs[1].f[1] = '{2, -6, -4096, 4095, 0, 0, -1, -1};
    vecs[1].f[2] = '{2, -6, -4096, 4095, 0, 1,  0, -1};
    vecs[1].f[3] = '{2, -7, -4096, 4095, 1, 1,  0,  0};
    vecs[1].e    = '{2, -6, -4096, 4095, 0, 1,  0, -1};

    vecs[2].name = "mixed";
    vecs[2].f[0] = '{10, -10,  4095, -4096, 3, 1, 1, -2};
    vecs[2].f[1] = '{20, -20,  4095, -4096, 3, 0, 1, -1};
    vecs[2].f[2] = '{30, -30,  4095, -4096, 3, 0, 0, -1};
    vecs[2].f[3] = '{41, -41, -4096,  4095, 3, 0, 0, -1};
    vecs[2].e    = '{25, -25,  2047, -2048, 3, 0, 1, -1};

    do_reset();
    chk("reset_busy", int'(busy2), 0);
    chk("reset_overrun", int'(ovr2), 0);
    chk("reset_avg_valid", int'(av2), 0);
    chk("reset_avg1", int'(avg2[0]), 0);

    for (int i = 0; i < 3; i++) begin
      for (int f = 0; f < 4; f++) blk[f] = vecs[i].f[f];
      block2(blk, vecs[i].name, lat);
      if (lat > 0) begin
        for (int k = 0; k < 8; k++)
          chk($sformatf("%s_avg%0d", vecs[i].name, k + 1), int'($signed(avg2[k])), vecs[i].e[k]);
        tick();
        chk({vecs[i].name, "_strobe_width"}, int'(av2), 0);
      end
      idle(3);
    end

    // ---------- overrun: drop 5 cycles after an accepted frame ----------
    do_reset();
    send_frame(fill(100));
    idle(4);
    for (int k = 0; k < 8; k++) ain[k] = 13'd999;
    ain_valid = 1'b1;
    chk("drop_busy", int'(busy2), 1);
    tick();
    ain_valid = 1'b0;
    chk("drop_overrun_set", int'(ovr2), 1);
    idle(6);
    for (int f = 1; f < 4; f++) begin
      send_frame(fill(100));
      if (f < 3) idle(11);
    end
    wait_strobe2(lat);
    chk("drop_latency", lat, 9);
    chk("drop_avg1", int'($signed(avg2[0])), 100);
    chk("drop_avg8", int'($signed(avg2[7])), 100);
    idle(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_overrun", int'(ovr2), 0);
    send_frame(fill(5));
    idle(2);
    ain_valid = 1'b1;
    tick();
    ain_valid = 1'b0;
    chk("drop2_overrun", int'(ovr2), 1);
    idle(1);
    ain_valid = 1'b1;
    clr = 1'b1;
    tick();
    ain_valid = 1'b0;
    clr = 1'b0;
    chk("clear_and_drop", int'(ovr2), 1);
    idle(10);

    // ---------- reset in the middle of accumulation ----------
    do_reset();
    for (int f = 0; f < 4; f++) blk[f] = fill(77);
    block2(blk, "pre_reset", lat);
    chk("pre_reset_avg1", int'($signed(avg2[0])), 77);
    idle(3);
    send_frame(fill(77));
    idle(11);
    send_frame(fill(77));
    idle(11);
    send_frame(fill(77));
    idle(1);
    ain_valid = 1'b1;
    tick();
    ain_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_busy", int'(busy2), 0);
    chk("midreset_overrun", int'(ovr2), 0);
    chk("midreset_avg_valid", int'(av2), 0);
    chk("midreset_avg1", int'(avg2[0]), 0);
    chk("midreset_avg8", int'(avg2[7]), 0);
    idle(2);
    for (int f = 0; f < 4; f++) blk[f] = fill(50);
    block2(blk, "post_reset", lat);
    chk("post_reset_avg1", int'($signed(avg2[0])), 50);
    chk("post_reset_avg5", int'($signed(avg2[4])), 50);
    chk("post_reset_avg8", int'($signed(avg2[7])), 50);

    // ---------- LOG2_N = 0 passthrough ----------
    do_reset();
    fa = '{1, -1, 2, -2, 4095, -4096, 0, 7};
    fb = '{7, 1, -1, 2, -2, 4095, -4096, 0};
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? fa : fb;
      send_frame(v);
      idle(8);
      chk($sformatf("n0_f%0d_early", i), int'(av0), 0);
      tick();
      chk($sformatf("n0_f%0d_strobe", i), int'(av0), 1);
      for (int k = 0; k < 8; k++)
        chk($sformatf("n0_f%0d_avg%0d", i, k + 1), int'($signed(avg0[k])), v[k]);
      tick();
      chk($sformatf("n0_f%0d_width", i), int'(av0), 0);
      idle(2);
    end

    // ---------- LOG2_N = 4 back-to-back random frames ----------
    do_reset();
    base = n4;
    for (int k = 0; k < 8; k++) s[k] = 0;
    for (int f = 0; f < 64; f++) begin
      for (int k = 0; k < 8; k++) begin
        r = 13'($urandom_range(0, 8191));
        v[k] = int'($signed(r));
        s[k] += v[k];
      end
      send_frame(v);
      if (f % 16 == 15) begin
        idle(9);
        chk($sformatf("n4_blk%0d_strobe", f / 16), int'(av4), 1);
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("n4_blk%0d_avg%0d", f / 16, k + 1), int'($signed(avg4[k])),
              (s[k] + 8) >>> 4);
          s[k] = 0;
        end
      end else begin
        idle(8);
      end
    end
    idle(3);
    chk("n4_strobe_count", n4 - base, 4);
    chk("n4_overrun", int'(ovr4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
